cpu_player: RTL and testbench

Computer opponent stage that consumes the 8-bit pseudo-random value from the LFSR generator and decides when the machine "presses its button". On each sample tick it compares the random value against a difficulty threshold from the switches. A hit produces a held press of fixed length, then a mandatory cooldown. The press output feeds the same edge-detect/scoring path as a human player's key.

---
 rtl/cpu_player_pkg.sv | 16 +
 rtl/cpu_player_cycle_timer.sv | 28 ++
 rtl/cpu_player.sv | 106 ++++++++++
 tb/tb_cpu_player.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpu_player_pkg.sv
// Shared types and constants for the computer-opponent press generator.
package cpu_player_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int unsigned DEF_HOLD_CYCLES     = 4;
  localparam int unsigned DEF_COOLDOWN_CYCLES = 8;
  localparam int unsigned TIMER_W             = 8;
  localparam int unsigned COUNT_W             = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX    = 8'd255;

endpackage

// File: rtl/cpu_player_cycle_timer.sv
// Loadable 8-bit down-counter shared by the press and cooldown phases.
module cycle_timer
  import cpu_player_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               clear,
  output logic               done
);

  logic [TIMER_W-1:0] cnt;

  // Clear beats load; otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/cpu_player.sv
// Computer opponent: random-vs-threshold decision on each tick, held press, then cooldown.
module cpu_player
  import cpu_player_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         tick,
  input  logic [7:0]   rand_num,
  input  logic [7:0]   level,
  output logic         press,
  output logic         press_pulse,
  output logic [7:0]   press_count
);

  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'(COOLDOWN_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic               hit_c;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_clear;
  logic               timer_done;
  logic               press_d;
  logic               pulse_d;
  logic [7:0]         count_d;

  assign hit_c = en & tick & (rand_num < level);

  cycle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .clear    (timer_clear),
    .done     (timer_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and timer control; en low forces IDLE and clears the timer.
  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_val   = '0;
    timer_clear = 1'b0;
    if (!en) begin
      state_d     = IDLE;
      timer_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_c) begin
            state_d    = PRESS;
            timer_load = 1'b1;
            timer_val  = HOLD_LOAD;
          end
        end
        PRESS: begin
          if (timer_done) begin
            state_d    = COOLDOWN;
            timer_load = 1'b1;
            timer_val  = COOL_LOAD;
          end
        end
        COOLDOWN: begin
          if (timer_done) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs align with it.
  always_comb begin
    press_d = (state_d == PRESS);
    pulse_d = (state_d == PRESS) && (state_q != PRESS);
    count_d = press_count;
    if ((state_q == IDLE) && (state_d == PRESS) && (press_count != COUNT_MAX)) begin
      count_d = press_count + 8'd1;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      press       <= 1'b0;
      press_pulse <= 1'b0;
      press_count <= '0;
    end else begin
      press       <= press_d;
      press_pulse <= pulse_d;
      press_count <= count_d;
    end
  end

endmodule

// File: tb/tb_cpu_player.sv
// Directed bench for cpu_player with default hold/cooldown lengths.
module tb_cpu_player;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       tick;
  logic [7:0] rand_num;
  logic [7:0] level;
  logic       press;
  logic       press_pulse;
  logic [7:0] press_count;

  int errors = 0;
  int checks = 0;
  int model_count;

  cpu_player dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .tick        (tick),
    .rand_num    (rand_num),
    .level       (level),
    .press       (press),
    .press_pulse (press_pulse),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with hit-favourable inputs present.
    rst = 1'b1; en = 1'b1; tick = 1'b1; rand_num = 8'h00; level = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_press", 32'(press), 32'd0);
      check("rst_pulse", 32'(press_pulse), 32'd0);
      check("rst_count", 32'(press_count), 32'd0);
    end
    rst = 1'b0; tick = 1'b0;
    step();
    check("post_rst_press", 32'(press), 32'd0);

    // Single hit: decision in cycle N, press N+1..N+4, cooldown N+5..N+12.
    level = 8'd128; rand_num = 8'h40; tick = 1'b1;
    step();
    tick = 1'b0; rand_num = 8'hFF; level = 8'h00;
    check("hit_press_n1", 32'(press), 32'd1);
    check("hit_pulse_n1", 32'(press_pulse), 32'd1);
    check("hit_count_n1", 32'(press_count), 32'd1);
    for (int k = 2; k <= 12; k++) begin
      step();
      check($sformatf("hit_press_n%0d", k), 32'(press), (k <= 4) ? 32'd1 : 32'd0);
      check($sformatf("hit_pulse_n%0d", k), 32'(press_pulse), 32'd0);
    end
    check("hit_count_n12", 32'(press_count), 32'd1);
    step();

    // Misses and strict-compare boundaries.
    rand_num = 8'h80; level = 8'h80; tick = 1'b1;
    step();
    check("miss_equal", 32'(press), 32'd0);
    level = 8'h00;
    step();
    check("miss_level0", 32'(press), 32'd0);
    rand_num = 8'hFF; level = 8'hFF;
    step();
    check("miss_255", 32'(press), 32'd0);
    check("miss_count", 32'(press_count), 32'd1);

    // Tick every cycle: presses begin 13 cycles apart.
    rand_num = 8'h00; level = 8'hFF; tick = 1'b1;
    step();
    check("rep_press_0", 32'(press), 32'd1);
    check("rep_pulse_0", 32'(press_pulse), 32'd1);
    check("rep_count_0", 32'(press_count), 32'd2);
    for (int k = 1; k <= 13; k++) begin
      step();
      check($sformatf("rep_press_%0d", k), 32'(press), (k < 4 || k == 13) ? 32'd1 : 32'd0);
      check($sformatf("rep_pulse_%0d", k), 32'(press_pulse), (k == 13) ? 32'd1 : 32'd0);
    end
    check("rep_count_13", 32'(press_count), 32'd3);

    // Abort: en drops in cycle N+2 of the press started above.
    tick = 1'b0;
    step();
    check("abort_n2_press", 32'(press), 32'd1);
    en = 1'b0;
    step();
    check("abort_n3_press", 32'(press), 32'd0);
    check("abort_n3_count", 32'(press_count), 32'd3);
    tick = 1'b1;
    step();
    check("en_low_hit_press", 32'(press), 32'd0);
    check("en_low_hit_count", 32'(press_count), 32'd3);
    en = 1'b1;
    step();
    check("resume_press", 32'(press), 32'd1);
    check("resume_pulse", 32'(press_pulse), 32'd1);
    check("resume_count", 32'(press_count), 32'd4);

    // Saturation: 260 more hits with a tick every cycle.
    model_count = 4;
    for (int i = 1; i <= 13 * 260; i++) begin
      int off;
      step();
      off = i % 13;
      if (off == 0 && model_count < 255) model_count++;
      if (off < 4) begin
        if (press !== 1'b1) check($sformatf("sat_press_%0d", i), 32'(press), 32'd1);
      end else begin
        if (press !== 1'b0) check($sformatf("sat_press_%0d", i), 32'(press), 32'd0);
      end
      if (off == 0) check($sformatf("sat_count_%0d", i), 32'(press_count), 32'(model_count));
    end
    check("sat_final_count", 32'(press_count), 32'd255);
    check("sat_final_press", 32'(press), 32'd1);
    check("sat_final_pulse", 32'(press_pulse), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
